// File: rtl/wb_master_arb.sv
// Two-master (MMU/DMA) round-robin wishbone arbiter; grant is held until the owner drops cyc.
// Define ARB_TIMEOUT_EN to add a slave-response watchdog that aborts a stalled cycle.
module wb_master_arb #(
    parameter int unsigned TIMEOUT_CYC = 64,
    parameter int unsigned CNT_W       = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_mmu_cyc,
    input  logic        m_mmu_we,
    input  logic [3:0]  m_mmu_strb,
    input  logic [31:0] m_mmu_addr,
    input  logic [31:0] m_mmu_data_i,
    output logic        m_mmu_ack,
    output logic        m_mmu_err,
    output logic        m_mmu_gnt,
    input  logic        m_dma_cyc,
    input  logic        m_dma_we,
    input  logic [3:0]  m_dma_strb,
    input  logic [31:0] m_dma_addr,
    input  logic [31:0] m_dma_data_i,
    output logic        m_dma_ack,
    output logic        m_dma_err,
    output logic        m_dma_gnt,
    output logic        s_cyc,
    output logic        s_we,
    output logic [3:0]  s_strb,
    output logic [31:0] s_addr,
    output logic [31:0] s_data_o,
    input  logic        s_ack,
    input  logic [31:0] s_data_i
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StGntMmu = 2'd1;
    localparam logic [1:0] StGntDma = 2'd2;
    localparam logic [1:0] StAbort  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_dma_q, last_dma_d;
    logic       gnt_mmu, gnt_dma, cyc_int, timeout, run;

    // Read data is routed to both masters outside this block.
    logic unused_rdata;
    assign unused_rdata = ^s_data_i;

    assign gnt_mmu = (state_q == StGntMmu);
    assign gnt_dma = (state_q == StGntDma);
    assign cyc_int = (gnt_mmu & m_mmu_cyc) | (gnt_dma & m_dma_cyc);
    assign run     = ~rst;

`ifdef ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] Limit = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_mmu_q, err_dma_q;

    // An ack in the limit cycle wins over the timeout.
    assign timeout = cyc_int & ~s_ack & (cnt_q == Limit);
    assign cnt_d   = (cyc_int & ~s_ack) ? cnt_q + CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            err_mmu_q <= 1'b0;
            err_dma_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            err_mmu_q <= timeout & gnt_mmu;
            err_dma_q <= timeout & gnt_dma;
        end
    end

    assign m_mmu_err = run & err_mmu_q;
    assign m_dma_err = run & err_dma_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{TIMEOUT_CYC, CNT_W};
    assign timeout    = 1'b0;
    assign m_mmu_err  = 1'b0;
    assign m_dma_err  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        last_dma_d = last_dma_q;
        case (state_q)
            StIdle: begin
                if (m_mmu_cyc && (!m_dma_cyc || last_dma_q)) begin
                    state_d = StGntMmu;
                end else if (m_dma_cyc) begin
                    state_d = StGntDma;
                end
            end
            StGntMmu: begin
                if (timeout) begin
                    state_d    = StAbort;
                    last_dma_d = 1'b0;
                end else if (!m_mmu_cyc) begin
                    last_dma_d = 1'b0;
                    state_d    = m_dma_cyc ? StGntDma : StIdle;
                end
            end
            StGntDma: begin
                if (timeout) begin
                    state_d    = StAbort;
                    last_dma_d = 1'b1;
                end else if (!m_dma_cyc) begin
                    last_dma_d = 1'b1;
                    state_d    = m_mmu_cyc ? StGntMmu : StIdle;
                end
            end
            StAbort: begin
                // last_dma_q names the aborted master; wait for it to release.
                if (last_dma_q && !m_dma_cyc) begin
                    state_d = m_mmu_cyc ? StGntMmu : StIdle;
                end else if (!last_dma_q && !m_mmu_cyc) begin
                    state_d = m_dma_cyc ? StGntDma : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            last_dma_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            last_dma_q <= last_dma_d;
        end
    end

    always_comb begin
        m_mmu_gnt = run & gnt_mmu;
        m_dma_gnt = run & gnt_dma;
        m_mmu_ack = run & gnt_mmu & s_ack;
        m_dma_ack = run & gnt_dma & s_ack;
        s_cyc     = run & cyc_int;
        s_we      = 1'b0;
        s_strb    = 4'h0;
        s_addr    = 32'h0;
        s_data_o  = 32'h0;
        if (run && gnt_mmu) begin
            s_we     = m_mmu_we;
            s_strb   = m_mmu_strb;
            s_addr   = m_mmu_addr;
            s_data_o = m_mmu_data_i;
        end else if (run && gnt_dma) begin
            s_we     = m_dma_we;
            s_strb   = m_dma_strb;
            s_addr   = m_dma_addr;
            s_data_o = m_dma_data_i;
        end
    end

endmodule

// File: tb/tb_wb_master_arb.sv
// Randomised bench for wb_master_arb against a cycle-level ownership model.
// Timeout behaviour is modelled only when ARB_TIMEOUT_EN is defined.
module tb_wb_master_arb;

    localparam int unsigned TO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        m_mmu_cyc, m_mmu_we, m_mmu_ack, m_mmu_err, m_mmu_gnt;
    logic [3:0]  m_mmu_strb;
    logic [31:0] m_mmu_addr, m_mmu_data_i;
    logic        m_dma_cyc, m_dma_we, m_dma_ack, m_dma_err, m_dma_gnt;
    logic [3:0]  m_dma_strb;
    logic [31:0] m_dma_addr, m_dma_data_i;
    logic        s_cyc, s_we, s_ack;
    logic [3:0]  s_strb;
    logic [31:0] s_addr, s_data_o, s_data_i;

    wb_master_arb #(
        .TIMEOUT_CYC(TO),
        .CNT_W      (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .m_mmu_cyc   (m_mmu_cyc),
        .m_mmu_we    (m_mmu_we),
        .m_mmu_strb  (m_mmu_strb),
        .m_mmu_addr  (m_mmu_addr),
        .m_mmu_data_i(m_mmu_data_i),
        .m_mmu_ack   (m_mmu_ack),
        .m_mmu_err   (m_mmu_err),
        .m_mmu_gnt   (m_mmu_gnt),
        .m_dma_cyc   (m_dma_cyc),
        .m_dma_we    (m_dma_we),
        .m_dma_strb  (m_dma_strb),
        .m_dma_addr  (m_dma_addr),
        .m_dma_data_i(m_dma_data_i),
        .m_dma_ack   (m_dma_ack),
        .m_dma_err   (m_dma_err),
        .m_dma_gnt   (m_dma_gnt),
        .s_cyc       (s_cyc),
        .s_we        (s_we),
        .s_strb      (s_strb),
        .s_addr      (s_addr),
        .s_data_o    (s_data_o),
        .s_ack       (s_ack),
        .s_data_i    (s_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: owner 0 = nobody, 1 = MMU, 2 = DMA, 3 = aborted cycle draining.
    int owner    = 0;
    int last     = 2;
    int aborted  = 0;
    int wait_cyc = 0;
    int err_who  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cyc_of(input int who);
        if (who == 1) return m_mmu_cyc;
        if (who == 2) return m_dma_cyc;
        return 1'b0;
    endfunction

    task automatic check_outputs();
        logic        e_gm, e_gd, e_am, e_ad, e_em, e_ed, e_cyc, e_we;
        logic [3:0]  e_strb;
        logic [31:0] e_addr, e_data;
        {e_gm, e_gd, e_am, e_ad, e_em, e_ed, e_cyc, e_we} = '0;
        e_strb = '0;
        e_addr = '0;
        e_data = '0;
        if (!rst) begin
            if (owner == 1) begin
                e_gm = 1'b1; e_cyc = m_mmu_cyc; e_we = m_mmu_we; e_am = s_ack;
                e_strb = m_mmu_strb; e_addr = m_mmu_addr; e_data = m_mmu_data_i;
            end else if (owner == 2) begin
                e_gd = 1'b1; e_cyc = m_dma_cyc; e_we = m_dma_we; e_ad = s_ack;
                e_strb = m_dma_strb; e_addr = m_dma_addr; e_data = m_dma_data_i;
            end
            e_em = (err_who == 1);
            e_ed = (err_who == 2);
        end
        check("mmu_gnt", 32'(m_mmu_gnt), 32'(e_gm));
        check("dma_gnt", 32'(m_dma_gnt), 32'(e_gd));
        check("mmu_ack", 32'(m_mmu_ack), 32'(e_am));
        check("dma_ack", 32'(m_dma_ack), 32'(e_ad));
        check("mmu_err", 32'(m_mmu_err), 32'(e_em));
        check("dma_err", 32'(m_dma_err), 32'(e_ed));
        check("s_cyc", 32'(s_cyc), 32'(e_cyc));
        check("s_we", 32'(s_we), 32'(e_we));
        check("s_strb", 32'(s_strb), 32'(e_strb));
        check("s_addr", s_addr, e_addr);
        check("s_data_o", s_data_o, e_data);
    endtask

    task automatic model_edge();
        bit cur_cyc;
        bit expired;
        if (rst) begin
            owner = 0; last = 2; wait_cyc = 0; err_who = 0;
        end else begin
            cur_cyc  = (owner == 1 || owner == 2) ? cyc_of(owner) : 1'b0;
            expired  = TO_EN && cur_cyc && !s_ack && (wait_cyc == int'(TO) - 1);
            wait_cyc = (cur_cyc && !s_ack) ? wait_cyc + 1 : 0;
            err_who  = 0;
            if (owner == 0) begin
                if (m_mmu_cyc && m_dma_cyc) owner = (last == 1) ? 2 : 1;
                else if (m_mmu_cyc)         owner = 1;
                else if (m_dma_cyc)         owner = 2;
            end else if (owner == 3) begin
                if (!cyc_of(aborted)) owner = cyc_of(3 - aborted) ? 3 - aborted : 0;
            end else if (expired) begin
                err_who = owner; aborted = owner; last = owner; owner = 3;
            end else if (!cur_cyc) begin
                last  = owner;
                owner = cyc_of(3 - owner) ? 3 - owner : 0;
            end
        end
    endtask

    // Inputs are set just after a falling edge; outputs are checked 1 ns later.
    task automatic step();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
    endtask

    task automatic run_random(input int n, input int ack_pct, input int flip_pct,
                              input int rst_pm);
        for (int i = 0; i < n; i++) begin
            if (($urandom % 100) < flip_pct) m_mmu_cyc = ~m_mmu_cyc;
            if (($urandom % 100) < flip_pct) m_dma_cyc = ~m_dma_cyc;
            s_ack        = (($urandom % 100) < ack_pct);
            rst          = (($urandom % 1000) < rst_pm);
            m_mmu_we     = $urandom_range(0, 1);
            m_mmu_strb   = 4'($urandom);
            m_mmu_addr   = $urandom;
            m_mmu_data_i = $urandom;
            m_dma_we     = $urandom_range(0, 1);
            m_dma_strb   = 4'($urandom);
            m_dma_addr   = $urandom;
            m_dma_data_i = $urandom;
            s_data_i     = $urandom;
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {m_mmu_cyc, m_mmu_we, m_dma_cyc, m_dma_we, s_ack} = '0;
        m_mmu_strb = '0; m_mmu_addr = '0; m_mmu_data_i = '0;
        m_dma_strb = '0; m_dma_addr = '0; m_dma_data_i = '0;
        s_data_i = '0;
        @(negedge clk);
        do_reset();
        step();

        // Single MMU read.
        m_mmu_cyc = 1'b1; m_mmu_addr = 32'h0000_0100; m_mmu_strb = 4'hf;
        step(); step();
        s_ack = 1'b1; step();
        s_ack = 1'b0; m_mmu_cyc = 1'b0; step(); step();

        // Simultaneous request after reset: MMU first, then DMA with no idle gap.
        do_reset();
        m_mmu_cyc = 1'b1; m_dma_cyc = 1'b1; m_dma_we = 1'b1;
        m_dma_strb = 4'b1111; m_dma_addr = 32'h0000_2000; m_dma_data_i = 32'hdead_beef;
        step(); step();
        s_ack = 1'b1; step();
        s_ack = 1'b0; m_mmu_cyc = 1'b0; step(); step();

        // DMA burst of 4 acks while MMU waits.
        m_mmu_cyc = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_ack = 1'b1; step();
            s_ack = 1'b0; step();
        end
        m_dma_cyc = 1'b0; step(); step();

        // Reset during a DMA grant with DMA cyc still high.
        m_mmu_cyc = 1'b0; m_dma_cyc = 1'b1; step(); step(); step();
        rst = 1'b1; step();
        rst = 1'b0; step(); step(); step();

        // Stalled slave with DMA pending.
        do_reset();
        m_dma_cyc = 1'b0; m_mmu_cyc = 1'b1; step();
        m_dma_cyc = 1'b1;
        for (int i = 0; i < 12; i++) step();
        m_mmu_cyc = 1'b0; step(); step(); step();
        m_dma_cyc = 1'b0; step();

        // Ack lands exactly in the limit cycle.
        do_reset();
        m_mmu_cyc = 1'b1; step();
        for (int i = 0; i < int'(TO) - 1; i++) step();
        s_ack = 1'b1; step();
        s_ack = 1'b0;
        for (int i = 0; i < 4; i++) step();
        m_mmu_cyc = 1'b0; step(); step();

        run_random(1500, 30, 15, 10);
        run_random(800, 0, 5, 5);
        run_random(800, 70, 30, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
